// File: rtl/seg_display_decoder.sv
// Four-digit MM:SS 7-segment scanner: shadow capture, per-digit decode, time-multiplexed
// active-low drive with guard cycles, leading-zero blanking, blink and sticky bad-digit flag.

module seg_digit_dec (
  input  logic [3:0] bcd,
  output logic [6:0] seg_n
);
  always_comb begin
    seg_n = 7'b1111110;
    unique case (bcd)
      4'd0: seg_n = 7'b0000001;
      4'd1: seg_n = 7'b1001111;
      4'd2: seg_n = 7'b0010010;
      4'd3: seg_n = 7'b0000110;
      4'd4: seg_n = 7'b1001100;
      4'd5: seg_n = 7'b0100100;
      4'd6: seg_n = 7'b0100000;
      4'd7: seg_n = 7'b0001111;
      4'd8: seg_n = 7'b0000000;
      4'd9: seg_n = 7'b0000100;
      default: seg_n = 7'b1111110;
    endcase
  end
endmodule

module seg_display_decoder #(
  parameter int SCAN_DIV     = 100,
  parameter int BLINK_FRAMES = 50
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic [15:0] digits_in,
  input  logic        blank_lz,
  input  logic        blink_en,
  output logic [6:0]  seg_n,
  output logic        dp_n,
  output logic [3:0]  an_n,
  output logic        digit_err
);
  localparam int NUM_DIGITS = 4;
  localparam int CW = $clog2(SCAN_DIV);
  localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  logic [NUM_DIGITS-1:0][3:0] shadow;
  logic [NUM_DIGITS-1:0][6:0] dec_seg;
  logic [NUM_DIGITS-1:0]      in_bad;
  logic [CW-1:0]              cnt;
  logic [1:0]                 idx;
  logic [BW-1:0]              bcnt;
  logic                       hidden;

  genvar g;
  generate
    for (g = 0; g < NUM_DIGITS; g++) begin : g_dig
      seg_digit_dec u_dec (.bcd(shadow[g]), .seg_n(dec_seg[g]));
      assign in_bad[g] = (digits_in[g*4 +: 4] > 4'd9);
    end
  endgenerate

  logic slot_end, frame_end, blink_wrap;
  assign slot_end   = (cnt == CW'(SCAN_DIV-1));
  assign frame_end  = slot_end && (idx == 2'd3);
  assign blink_wrap = (bcnt == BW'(BLINK_FRAMES-1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow    <= '0;
      digit_err <= 1'b0;
    end else if (load) begin
      shadow    <= digits_in;
      digit_err <= digit_err | (|in_bad);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      idx <= '0;
    end else if (slot_end) begin
      cnt <= '0;
      idx <= idx + 2'd1;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  // Blink phase only advances while enabled; disabling snaps back to visible.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bcnt   <= '0;
      hidden <= 1'b0;
    end else if (!blink_en) begin
      bcnt   <= '0;
      hidden <= 1'b0;
    end else if (frame_end) begin
      if (blink_wrap) begin
        bcnt   <= '0;
        hidden <= ~hidden;
      end else begin
        bcnt <= bcnt + BW'(1);
      end
    end
  end

  logic lz3, lz2, supp, guard;
  logic [6:0] seg_d;
  logic [3:0] an_d;
  logic       dp_d;

  always_comb begin
    lz3   = blank_lz && (shadow[3] == 4'd0);
    lz2   = lz3 && (shadow[2] == 4'd0);
    guard = (cnt == '0);
    supp  = (blink_en && hidden) || ((idx == 2'd3) && lz3) || ((idx == 2'd2) && lz2);
    seg_d = 7'h7F;
    an_d  = 4'hF;
    dp_d  = 1'b1;
    // Guard cycle blanks everything so a digit change never ghosts onto the next anode.
    if (!guard && !supp) begin
      seg_d = dec_seg[idx];
      an_d  = ~(4'b0001 << idx);
      dp_d  = (idx != 2'd2);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_n <= 7'h7F;
      an_n  <= 4'hF;
      dp_n  <= 1'b1;
    end else begin
      seg_n <= seg_d;
      an_n  <= an_d;
      dp_n  <= dp_d;
    end
  end
endmodule

// File: tb/tb_seg_display_decoder.sv
// Directed bench for seg_display_decoder with SCAN_DIV=4, BLINK_FRAMES=2.
module tb_seg_display_decoder;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        load = 1'b0;
  logic [15:0] digits_in = '0;
  logic        blank_lz = 1'b0;
  logic        blink_en = 1'b0;
  logic [6:0]  seg_n;
  logic        dp_n;
  logic [3:0]  an_n;
  logic        digit_err;

  int tests = 0;
  int fails = 0;

  localparam logic [6:0] S0 = 7'b0000001, S1 = 7'b1001111, S2 = 7'b0010010,
                         S3 = 7'b0000110, S4 = 7'b1001100, S5 = 7'b0100100,
                         S9 = 7'b0000100, SD = 7'b1111110, SB = 7'h7F;

  seg_display_decoder #(.SCAN_DIV(4), .BLINK_FRAMES(2)) dut (
    .clk(clk), .rst_n(rst_n), .load(load), .digits_in(digits_in),
    .blank_lz(blank_lz), .blink_en(blink_en), .seg_n(seg_n), .dp_n(dp_n),
    .an_n(an_n), .digit_err(digit_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock; load is a single-cycle pulse, sampling happens at the falling edge.
  task automatic tick();
    @(posedge clk);
    #1 load = 1'b0;
    @(negedge clk);
  endtask

  task automatic slot(input string tag, input logic [3:0] an, input logic [6:0] seg, input logic dp);
    tick();
    chk({tag, "_guard_an"}, 16'(an_n), 16'hF);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk({tag, "_an"}, 16'(an_n), 16'(an));
      chk({tag, "_seg"}, 16'(seg_n), 16'(seg));
      chk({tag, "_dp"}, 16'(dp_n), 16'(dp));
    end
  endtask

  task automatic frame_1234(input string tag);
    slot({tag, "_d0"}, 4'b1110, S4, 1'b1);
    slot({tag, "_d1"}, 4'b1101, S3, 1'b1);
    slot({tag, "_d2"}, 4'b1011, S2, 1'b0);
    slot({tag, "_d3"}, 4'b0111, S1, 1'b1);
  endtask

  task automatic frame_hidden(input string tag);
    for (int s = 0; s < 4; s++) slot(tag, 4'hF, SB, 1'b1);
  endtask

  initial begin
    @(negedge clk);
    @(negedge clk);
    chk("rst_seg", 16'(seg_n), 16'h7F);
    chk("rst_an", 16'(an_n), 16'hF);
    chk("rst_dp", 16'(dp_n), 16'h1);
    chk("rst_err", 16'(digit_err), 16'h0);
    rst_n = 1'b1;

    // Basic scan of 12:34
    digits_in = 16'h1234; load = 1'b1;
    frame_1234("f1234");
    chk("err_clean", 16'(digit_err), 16'h0);

    // Leading-zero blanking of 00:05
    digits_in = 16'h0005; load = 1'b1; blank_lz = 1'b1;
    slot("lz_d0", 4'b1110, S5, 1'b1);
    slot("lz_d1", 4'b1101, S0, 1'b1);
    slot("lz_d2", 4'hF, SB, 1'b1);
    slot("lz_d3", 4'hF, SB, 1'b1);
    blank_lz = 1'b0;
    slot("nolz_d0", 4'b1110, S5, 1'b1);
    slot("nolz_d1", 4'b1101, S0, 1'b1);
    slot("nolz_d2", 4'b1011, S0, 1'b0);
    slot("nolz_d3", 4'b0111, S0, 1'b1);

    // Invalid nibble: dash and sticky flag
    digits_in = 16'h12A4; load = 1'b1;
    tick();
    chk("err_set", 16'(digit_err), 16'h1);
    chk("err_guard_an", 16'(an_n), 16'hF);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("err_d0_seg", 16'(seg_n), 16'(S4));
    end
    slot("err_d1", 4'b1101, SD, 1'b1);
    slot("err_d2", 4'b1011, S2, 1'b0);
    slot("err_d3", 4'b0111, S1, 1'b1);
    digits_in = 16'h1234; load = 1'b1;
    frame_1234("reload");
    chk("err_sticky", 16'(digit_err), 16'h1);

    // Blink: 2 visible frames, 2 hidden, then deassert mid-hidden
    blink_en = 1'b1;
    frame_1234("blk_v1");
    frame_1234("blk_v2");
    frame_hidden("blk_h1");
    slot("blk_h2_d0", 4'hF, SB, 1'b1);
    slot("blk_h2_d1", 4'hF, SB, 1'b1);
    blink_en = 1'b0;
    slot("blk_off_d2", 4'b1011, S2, 1'b0);
    slot("blk_off_d3", 4'b0111, S1, 1'b1);

    // Asynchronous reset mid-slot at index 2
    slot("pre_rst_d0", 4'b1110, S4, 1'b1);
    slot("pre_rst_d1", 4'b1101, S3, 1'b1);
    tick();
    tick();
    chk("pre_rst_an", 16'(an_n), 16'(4'b1011));
    rst_n = 1'b0;
    #1;
    chk("arst_seg", 16'(seg_n), 16'h7F);
    chk("arst_an", 16'(an_n), 16'hF);
    chk("arst_dp", 16'(dp_n), 16'h1);
    chk("arst_err", 16'(digit_err), 16'h0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    slot("post_rst_d0", 4'b1110, S0, 1'b1);

    // Load on the last cycle of a slot: no torn digit
    tick();
    chk("tear_guard", 16'(an_n), 16'hF);
    tick();
    tick();
    digits_in = 16'h5959; load = 1'b1;
    tick();
    chk("tear_old_an", 16'(an_n), 16'(4'b1101));
    chk("tear_old_seg", 16'(seg_n), 16'(S0));
    slot("tear_d2", 4'b1011, S9, 1'b0);
    slot("tear_d3", 4'b0111, S5, 1'b1);
    slot("tear_d0", 4'b1110, S9, 1'b1);
    slot("tear_d1", 4'b1101, S5, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
